// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave cook-time controller.
package microwave_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_RUNNING,
    S_PAUSED,
    S_DONE
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t KEY_MAX         = 4'd9;
  localparam bcd_t SEC_TENS_RELOAD = 4'd5;
  localparam bcd_t DIGIT_RELOAD    = 4'd9;

endpackage

// File: rtl/microwave_timer_ctrl_if.sv
// Front-panel bundle: keypad/button strobes in, time display and status out.
interface microwave_timer_ctrl_if;
  import microwave_pkg::*;

  logic        tick;
  logic        key_valid;
  bcd_t        key_code;
  logic        start;
  logic        stop;
  logic        door_open;
  logic [15:0] digits;
  logic        mag_on;
  logic        done;

  modport master (
    output tick, key_valid, key_code, start, stop, door_open,
    input  digits, mag_on, done
  );

  modport slave (
    input  tick, key_valid, key_code, start, stop, door_open,
    output digits, mag_on, done
  );

endinterface

// File: rtl/microwave_timer_ctrl_digit.sv
// One BCD down-counting digit: load wins over decrement, wraps to RELOAD on borrow.
module bcd_down_digit
  import microwave_pkg::*;
#(
  parameter bcd_t RELOAD = DIGIT_RELOAD
) (
  input  logic clk,
  input  logic clr,
  input  logic load,
  input  bcd_t load_val,
  input  logic dec,
  output bcd_t q,
  output logic borrow
);

  bcd_t q_q, q_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    q_d = q_q;
    if (load)     q_d = load_val;
    else if (dec) q_d = (q_q == 4'd0) ? RELOAD : q_q - 4'd1;
  end

  // NOTE: state flops use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (clr) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q      = q_q;
  assign borrow = dec && (q_q == 4'd0);

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Cook-time controller: keypad entry into MM:SS, 1 Hz countdown, magnetron and done control.
module microwave_timer_ctrl
  import microwave_pkg::*;
#(
  parameter int DONE_TICKS = 3
) (
  input logic                          clk,
  input logic                          clr,
  microwave_timer_ctrl_if.slave        bus
);

  localparam int CNT_W = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;

  state_e             state_q, state_d;
  logic               mag_on_q, mag_on_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  bcd_t               dig_q    [4];
  bcd_t               load_val [4];
  logic               digit_load;
  logic [4:0]         dec_chain;
  logic               dec_tick;
  logic               key_ok;
  logic [15:0]        digits;

  assign digits = {dig_q[3], dig_q[2], dig_q[1], dig_q[0]};
  assign key_ok = bus.key_valid && (bus.key_code <= KEY_MAX);

  // Decrement only when no higher-priority button acts in this cycle.
  assign dec_tick     = (state_q == S_RUNNING) && !bus.stop && !bus.door_open && bus.tick;
  assign dec_chain[0] = dec_tick;

  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_down_digit #(
      .RELOAD((i == 1) ? SEC_TENS_RELOAD : DIGIT_RELOAD)
    ) u_digit (
      .clk      (clk),
      .clr      (clr),
      .load     (digit_load),
      .load_val (load_val[i]),
      .dec      (dec_chain[i]),
      .q        (dig_q[i]),
      .borrow   (dec_chain[i+1])
    );
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    digit_load = 1'b0;
    for (int i = 0; i < 4; i++) load_val[i] = '0;

    unique case (state_q)
      S_IDLE, S_ENTRY: begin
        if (bus.stop) begin
          digit_load = 1'b1;
          state_d    = S_IDLE;
        end else if (state_q == S_ENTRY && bus.start && !bus.door_open && digits != 16'h0000) begin
          state_d = S_RUNNING;
        end else if (key_ok) begin
          digit_load  = 1'b1;
          load_val[3] = dig_q[2];
          load_val[2] = dig_q[1];
          load_val[1] = dig_q[0];
          load_val[0] = bus.key_code;
          state_d     = S_ENTRY;
        end
      end
      S_RUNNING: begin
        if (bus.stop || bus.door_open) begin
          state_d = S_PAUSED;
        end else if (dec_tick && (digits == 16'h0001 || dec_chain[4])) begin
          // Only 00:01 steps to 00:00; an underflow out of m1 is treated the same.
          digit_load = dec_chain[4];
          state_d    = S_DONE;
        end
      end
      S_PAUSED: begin
        if (bus.stop) begin
          digit_load = 1'b1;
          state_d    = S_IDLE;
        end else if (bus.start && !bus.door_open) begin
          state_d = S_RUNNING;
        end
      end
      S_DONE: begin
        cnt_d = cnt_q;
        if (bus.stop || bus.key_valid) begin
          state_d = S_IDLE;
        end else if (bus.tick) begin
          if (cnt_q == CNT_W'(DONE_TICKS - 1)) state_d = S_IDLE;
          else                                 cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    mag_on_d = (state_d == S_RUNNING);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_IDLE;
      mag_on_q <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mag_on_q <= mag_on_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.digits = digits;
  assign bus.mag_on = mag_on_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed bench for microwave_timer_ctrl: hand-computed expectations checked by immediate assertions.
module tb_microwave_timer_ctrl;
  import microwave_pkg::*;

  logic clk;
  logic clr;
  int   n_vec;
  int   n_err;

  microwave_timer_ctrl_if bus ();

  microwave_timer_ctrl #(.DONE_TICKS(3)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input state_e exp);
    n_vec++;
    assert (dut.state_q === exp) else begin
      n_err++;
      $error("FAIL %s: observed state %0d expected %0d", tag, dut.state_q, exp);
    end
  endtask

  task automatic key(input logic [3:0] k);
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    step();
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
  endtask

  task automatic press_start();
    bus.start = 1'b1; step(); bus.start = 1'b0;
  endtask

  task automatic press_stop();
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
  endtask

  task automatic do_tick();
    bus.tick = 1'b1; step(); bus.tick = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clr = 1'b1;
    bus.tick = 1'b0; bus.key_valid = 1'b0; bus.key_code = 4'd0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.door_open = 1'b0;
    step(); step();
    clr = 1'b0;

    chk("rst_digits", bus.digits, 16'h0000);
    chk("rst_mag",    {15'd0, bus.mag_on}, 16'd0);
    chk("rst_done",   {15'd0, bus.done},   16'd0);
    chk_state("rst_state", S_IDLE);

    // Non-digit key and start in IDLE do nothing.
    key(4'd12);
    chk("idle_badkey", bus.digits, 16'h0000);
    press_start();
    chk("idle_start_mag", {15'd0, bus.mag_on}, 16'd0);

    key(4'd1); key(4'd3); key(4'd0);
    chk("entry_130", bus.digits, 16'h0130);
    chk_state("entry_state", S_ENTRY);
    chk("entry_mag", {15'd0, bus.mag_on}, 16'd0);

    // 01:00 counts to 00:59 then 00:58.
    press_stop();
    chk("stop_clear", bus.digits, 16'h0000);
    key(4'd1); key(4'd0); key(4'd0);
    press_start();
    chk("run_mag", {15'd0, bus.mag_on}, 16'd1);
    chk("run_hold", bus.digits, 16'h0100);
    do_tick();
    chk("run_0059", bus.digits, 16'h0059);
    do_tick();
    chk("run_0058", bus.digits, 16'h0058);
    chk("run_mag2", {15'd0, bus.mag_on}, 16'd1);
    step();
    chk("run_notick", bus.digits, 16'h0058);
    press_stop();
    chk("pause_mag", {15'd0, bus.mag_on}, 16'd0);
    chk("pause_hold", bus.digits, 16'h0058);
    press_stop();
    chk("pause_stop", bus.digits, 16'h0000);
    chk_state("pause_stop_st", S_IDLE);

    // Expiry and DONE_TICKS hold time.
    key(4'd2);
    press_start();
    do_tick();
    chk("exp_0001", bus.digits, 16'h0001);
    chk("exp_done0", {15'd0, bus.done}, 16'd0);
    do_tick();
    chk("exp_0000", bus.digits, 16'h0000);
    chk("exp_done1", {15'd0, bus.done}, 16'd1);
    chk("exp_mag0", {15'd0, bus.mag_on}, 16'd0);
    do_tick();
    chk("done_t1", {15'd0, bus.done}, 16'd1);
    step();
    chk("done_idle", {15'd0, bus.done}, 16'd1);
    do_tick();
    chk("done_t2", {15'd0, bus.done}, 16'd1);
    do_tick();
    chk("done_t3", {15'd0, bus.done}, 16'd0);
    chk_state("done_to_idle", S_IDLE);

    // Key in DONE leaves immediately and is not consumed.
    key(4'd1);
    press_start();
    do_tick();
    chk("done_b_done", {15'd0, bus.done}, 16'd1);
    key(4'd7);
    chk("done_key_done", {15'd0, bus.done}, 16'd0);
    chk("done_key_dig", bus.digits, 16'h0000);
    chk_state("done_key_st", S_IDLE);

    // Door open together with a tick: pause without decrement.
    key(4'd3); key(4'd0);
    press_start();
    bus.door_open = 1'b1; bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    chk("door_hold", bus.digits, 16'h0030);
    chk("door_mag", {15'd0, bus.mag_on}, 16'd0);
    chk_state("door_state", S_PAUSED);
    press_start();
    chk("door_start_ign", {15'd0, bus.mag_on}, 16'd0);
    bus.door_open = 1'b0;
    step();
    chk("door_no_latch", {15'd0, bus.mag_on}, 16'd0);
    press_start();
    chk("resume_mag", {15'd0, bus.mag_on}, 16'd1);
    chk("resume_dig", bus.digits, 16'h0030);
    do_tick();
    chk("resume_0029", bus.digits, 16'h0029);
    press_stop(); press_stop();

    // Five keys: oldest digit falls off the top.
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    chk("shift_2345", bus.digits, 16'h2345);
    press_stop();
    chk("shift_stop", bus.digits, 16'h0000);
    press_start();
    chk("zero_start", {15'd0, bus.mag_on}, 16'd0);

    // Seconds-tens counts down from entered 7, borrow across minutes.
    key(4'd7); key(4'd0);
    press_start();
    do_tick();
    chk("s1_0069", bus.digits, 16'h0069);
    press_stop(); press_stop();
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    press_start();
    do_tick();
    chk("m1_0959", bus.digits, 16'h0959);
    press_stop(); press_stop();
    key(4'd9); key(4'd9); key(4'd9); key(4'd9);
    press_start();
    do_tick();
    chk("max_9998", bus.digits, 16'h9998);
    press_stop(); press_stop();

    // Synchronous clear while running.
    key(4'd5); key(4'd1); key(4'd2);
    press_start();
    chk("clr_pre_mag", {15'd0, bus.mag_on}, 16'd1);
    clr = 1'b1; bus.tick = 1'b1; bus.start = 1'b1;
    step();
    clr = 1'b0; bus.tick = 1'b0; bus.start = 1'b0;
    chk("clr_digits", bus.digits, 16'h0000);
    chk("clr_mag", {15'd0, bus.mag_on}, 16'd0);
    chk("clr_done", {15'd0, bus.done}, 16'd0);
    chk_state("clr_state", S_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/microwave_timer_ctrl.md
# microwave_timer_ctrl

Cook-time controller for the microwave front panel: accepts keypad digits into a 4-digit BCD time (MM:SS), counts it down once per 1 Hz tick while cooking, and drives the magnetron enable and the done indication. It sits between the keypad/button decoder and the display driver. It owns the cascade of BCD down-counting digits and sequences their load, decrement and clear.

## Interface
Parameters:
- DONE_TICKS, 3: number of `tick` strobes `done` stays asserted before the block returns to IDLE.

Ports:
- clk  in  1  system clock; single clock domain.
- clr  in  1  reset; synchronous, active-high.
- tick  in  1  one-cycle 1 Hz strobe.
- key_valid  in  1  one-cycle keypad strobe.
- key_code  in  4  keypad value; 0–9 are digits, 10–15 are ignored.
- start  in  1  start/resume button, one-cycle strobe.
- stop  in  1  pause/cancel button, one-cycle strobe.
- door_open  in  1  door switch level.
- digits  out  16  {m1,m0,s1,s0}, BCD, m1 in MSBs.
- mag_on  out  1  magnetron enable.
- done  out  1  cooking-finished indicator.

## Operation
- States: IDLE, ENTRY, RUNNING, PAUSED, DONE.
- Input priority within one cycle: clr > stop > door_open > start > key_valid > tick. Only the highest-priority applicable event acts.
- IDLE:
  - digits = 0000.
  - A valid digit key shifts in as s0 and moves the block to ENTRY.
  - start is ignored.
- ENTRY:
  - Each valid digit shifts left: m1←m0, m0←s1, s1←s0, s0←key. Old m1 is discarded.
  - start with digits≠0000 and door closed → RUNNING.
  - start with digits=0000 is ignored.
  - stop → digits cleared to 0000, IDLE.
- RUNNING:
  - mag_on=1.
  - Each tick decrements the time.
  - stop or door_open → PAUSED; no decrement that cycle.
  - Keys are ignored.
- PAUSED:
  - Time is held.
  - start with door closed → RUNNING.
  - stop → clear to 0000, IDLE.
  - Keys are ignored.
- DONE:
  - digits = 0000, done=1.
  - After DONE_TICKS ticks → IDLE.
  - stop or key_valid → IDLE immediately; the key is not consumed.
- Decrement rules:
  - s0 is mod 10. m0 and m1 are mod 10.
  - s1 counts down normally from any entered value 0–9, and reloads 5 on borrow from 0. Typed 0075 therefore counts 75,74,…,70,69,…
  - Borrow propagates s0→s1→m0→m1.
  - A tick that produces 0000 moves the block to DONE on the same edge.
- Entered values above 99:59 are legal. Maximum is 9999.

## Timing
- All outputs are registered. Reset values: digits=0000, mag_on=0, done=0, state=IDLE.
- Key, start, stop and tick take effect on the next edge; the visible result appears one cycle after the strobe.
- mag_on rises the cycle after start is accepted. It falls the cycle after stop or door_open, or the cycle after the tick that reaches 0000.
- done rises together with mag_on falling at expiry.
- clr mid-operation returns the block to reset values on the next edge, regardless of other inputs.
- door_open held at start is ignored; start is not latched for later.
- DONE_TICKS counting starts with the first tick after DONE entry.

## Structure
- Shared package `microwave_pkg`:
  - state enum.
  - 4-bit BCD digit type.
  - KEY_MAX=9.
  - SEC_TENS_RELOAD=5.
  - DIGIT_RELOAD=9.
- Sub-module `bcd_down_digit`:
  - Parameter RELOAD.
  - Ports: clk, clr, load, load_val, dec, q, borrow.
  - borrow is combinational: dec && q==0.
  - Instantiated four times (RELOAD 9,9,5,9). The controller drives load for key shifts and clear, and dec chains through borrow.

## Test plan
- Reset then keys 1,3,0 → digits 0130 after third key+1 cycle; state ENTRY; mag_on=0.
- Entry 0100, start, one tick → digits 0059; second tick → 0058; mag_on=1 throughout.
- Entry 0002, start, two ticks → 0001 then 0000; done=1 and mag_on=0 the cycle after the 2nd tick; done clears after 3 further ticks.
- Running 0030: door_open asserted together with a tick → no decrement, PAUSED, mag_on=0 next cycle; close door and start → resumes from 0030.
- Keys 1,2,3,4,5 → digits 2345. stop → 0000 IDLE. start with 0000 → mag_on stays 0.
- clr asserted during RUNNING at 0512 → digits 0000, mag_on=0, done=0 next cycle.
